// File: rtl/ir_ctrl_pkg.sv
// ir_ctrl_pkg: shared definitions for NEC IR frame consumers.
//   - ir_state_e   : command controller FSM states
//   - CMD_*        : remote-key command codes (digits 0x00..CMD_DIG_MAX)
//   - FRM_*_LSB    : bit positions of the four 8-bit fields in a decoded frame
//   - cmd_known()  : true for any code in the supported command set
package ir_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      EXEC  = 2'd2,
      HOLD  = 2'd3
   } ir_state_e;

   localparam logic [7:0] CMD_DIG_MAX = 8'h09;
   localparam logic [7:0] CMD_CLR     = 8'h0A;
   localparam logic [7:0] CMD_BS      = 8'h0B;
   localparam logic [7:0] CMD_ENT     = 8'h0C;

   localparam int unsigned FRM_ADDR_LSB  = 24;
   localparam int unsigned FRM_NADDR_LSB = 16;
   localparam int unsigned FRM_CMD_LSB   = 8;
   localparam int unsigned FRM_NCMD_LSB  = 0;

   function automatic logic cmd_known(input logic [7:0] cmd);
      return (cmd <= CMD_ENT);
   endfunction

endpackage

// File: rtl/ir_hold_tmr.sv
// ir_hold_tmr: loadable 32-bit down-counter used as the key-held timeout.
//   clk, rst_n : clock, asynchronous active-low reset (counter clears to 0)
//   load       : reload the counter with LOAD_VAL (wins over counting)
//   expire     : high in the cycle whose edge takes the counter from 1 to 0
module ir_hold_tmr #(
   parameter logic [31:0] LOAD_VAL = 32'd1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic expire
);

   logic [31:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= LOAD_VAL;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 32'd1;
      end
   end

   // A reload in the same cycle cancels the expiry.
   assign expire = !load && (cnt_q == 32'd1);

endmodule

// File: rtl/ir_cmd_ctrl.sv
// ir_cmd_ctrl: NEC IR command controller feeding a six-digit BCD display.
// Validates decoded frames, executes digit/clear/backspace/enter commands on a
// six-digit BCD entry buffer and tracks held keys with a repeat timeout.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_frame      : decoded frame {addr, ~addr, cmd, ~cmd}
//   i_frame_vld  : one-clk strobe, i_frame valid
//   i_rpt_vld    : one-clk strobe, NEC repeat code
//   o_digits     : entry buffer, six BCD nibbles, [3:0] rightmost
//   o_dp         : decimal points, one-hot cursor
//   o_value      : last committed buffer; o_value_vld pulses on commit
//   o_key        : last executed command
//   o_err_cnt    : saturating count of rejected or dropped frames
// Optional feature macro: IR_CMD_AUTOREPEAT_EN (every 4th repeat code in HOLD
// re-executes a held digit or backspace).
module ir_cmd_ctrl
   import ir_ctrl_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned HOLD_MS = 110,
   parameter logic [7:0]  ADDR    = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_frame,
   input  logic        i_frame_vld,
   input  logic        i_rpt_vld,
   output logic [23:0] o_digits,
   output logic [5:0]  o_dp,
   output logic [23:0] o_value,
   output logic        o_value_vld,
   output logic [7:0]  o_key,
   output logic [7:0]  o_err_cnt
);

   localparam logic [31:0] HOLD_CYC = 32'((CLK_HZ / 1000) * HOLD_MS);

   ir_state_e   state_q, state_d;
   logic [31:0] frame_q;
   logic [7:0]  f_addr, f_naddr, f_cmd, f_ncmd;
   logic        check_ok;
   logic        capture, exec_en, err_inc, tmr_load, tmr_expire;
   logic        rpt_fire;
   logic [7:0]  act_cmd;

   assign f_addr  = frame_q[FRM_ADDR_LSB  +: 8];
   assign f_naddr = frame_q[FRM_NADDR_LSB +: 8];
   assign f_cmd   = frame_q[FRM_CMD_LSB   +: 8];
   assign f_ncmd  = frame_q[FRM_NCMD_LSB  +: 8];

   assign check_ok = (f_addr == ADDR) && ((f_addr ^ f_naddr) == 8'hFF) &&
                     ((f_cmd ^ f_ncmd) == 8'hFF) && cmd_known(f_cmd);

   ir_hold_tmr #(.LOAD_VAL(HOLD_CYC)) u_hold_tmr (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (tmr_load),
      .expire (tmr_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      capture  = 1'b0;
      exec_en  = 1'b0;
      err_inc  = 1'b0;
      tmr_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_frame_vld) begin
               capture = 1'b1;
               state_d = CHECK;
            end
         end
         CHECK: begin
            // A failed check and a dropped frame in the same clk count once.
            err_inc = i_frame_vld || !check_ok;
            state_d = check_ok ? EXEC : IDLE;
         end
         EXEC: begin
            exec_en  = 1'b1;
            tmr_load = 1'b1;
            err_inc  = i_frame_vld;
            state_d  = HOLD;
         end
         HOLD: begin
            // New frame beats a simultaneous repeat; a repeat beats expiry.
            if (i_frame_vld) begin
               capture = 1'b1;
               state_d = CHECK;
            end else if (i_rpt_vld) begin
               tmr_load = 1'b1;
            end else if (tmr_expire) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       frame_q <= '0;
      else if (capture) frame_q <= i_frame;
   end

`ifdef IR_CMD_AUTOREPEAT_EN
   logic [1:0] rpt_cnt_q;
   logic       rpt_pend_q;

   // The re-execution is registered here and applied one clk after the strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_cnt_q  <= '0;
         rpt_pend_q <= 1'b0;
      end else begin
         rpt_pend_q <= 1'b0;
         if (exec_en) begin
            rpt_cnt_q <= '0;
         end else if (state_q == HOLD && i_rpt_vld && !i_frame_vld) begin
            rpt_cnt_q  <= rpt_cnt_q + 2'd1;
            rpt_pend_q <= (rpt_cnt_q == 2'd3) &&
                          ((o_key <= CMD_DIG_MAX) || (o_key == CMD_BS));
         end
      end
   end

   assign rpt_fire = rpt_pend_q;
`else
   assign rpt_fire = 1'b0;
`endif

   // Repeats act on the held key; fresh executions act on the checked frame.
   assign act_cmd = exec_en ? f_cmd : o_key;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_digits    <= '0;
         o_dp        <= 6'b000001;
         o_value     <= '0;
         o_value_vld <= 1'b0;
         o_key       <= '0;
         o_err_cnt   <= '0;
      end else begin
         o_value_vld <= 1'b0;
         if (exec_en) o_key <= f_cmd;
         if (exec_en || rpt_fire) begin
            if (act_cmd <= CMD_DIG_MAX) begin
               o_digits <= {o_digits[19:0], act_cmd[3:0]};
               o_dp     <= 6'b000001;
            end else if (act_cmd == CMD_CLR) begin
               o_digits <= '0;
               o_dp     <= 6'b000001;
            end else if (act_cmd == CMD_BS) begin
               o_digits <= {4'h0, o_digits[23:4]};
            end else if (act_cmd == CMD_ENT && exec_en) begin
               o_value     <= o_digits;
               o_value_vld <= 1'b1;
            end
         end
         if (err_inc && o_err_cnt != '1) o_err_cnt <= o_err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
module tb_ir_cmd_ctrl;
   import ir_ctrl_pkg::*;

   localparam int unsigned CLK_HZ   = 10_000;
   localparam int unsigned HOLD_MS  = 110;
   localparam logic [7:0]  ADDR     = 8'h00;
   localparam int unsigned HOLD_CYC = (CLK_HZ / 1000) * HOLD_MS;
   localparam int unsigned RPT_GAP  = (CLK_HZ / 1000) * 108;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] i_frame = '0;
   logic        i_frame_vld = 1'b0;
   logic        i_rpt_vld = 1'b0;
   logic [23:0] o_digits;
   logic [5:0]  o_dp;
   logic [23:0] o_value;
   logic        o_value_vld;
   logic [7:0]  o_key;
   logic [7:0]  o_err_cnt;

   ir_cmd_ctrl #(.CLK_HZ(CLK_HZ), .HOLD_MS(HOLD_MS), .ADDR(ADDR)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_frame     (i_frame),
      .i_frame_vld (i_frame_vld),
      .i_rpt_vld   (i_rpt_vld),
      .o_digits    (o_digits),
      .o_dp        (o_dp),
      .o_value     (o_value),
      .o_value_vld (o_value_vld),
      .o_key       (o_key),
      .o_err_cnt   (o_err_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: buffer kept as a decimal number below 10^6.
   int          m_buf = 0;
   int          m_val = 0;
   logic [7:0]  m_key = '0;
   int          m_err = 0;
   logic        m_vld = 1'b0;
   ir_state_e   st_n1;
   logic        vld_n2;

   function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
      return {a, ~a, c, ~c};
   endfunction

   function automatic logic [23:0] to_bcd(input int v);
      logic [23:0] r;
      int t;
      t = v;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic bit frame_ok(input logic [31:0] f);
      logic [7:0] a, na, c, nc;
      a = f[31:24]; na = f[23:16]; c = f[15:8]; nc = f[7:0];
      return (a == ADDR) && ((a ^ na) == 8'hFF) && ((c ^ nc) == 8'hFF) && (c <= 8'h0C);
   endfunction

   task automatic model_err();
      if (m_err < 255) m_err++;
   endtask

   task automatic model_cmd(input logic [7:0] c);
      m_key = c;
      if (c <= 8'h09)      m_buf = (m_buf * 10 + int'(c)) % 1_000_000;
      else if (c == 8'h0A) m_buf = 0;
      else if (c == 8'h0B) m_buf = m_buf / 10;
      else begin
         m_val = m_buf;
         m_vld = 1'b1;
      end
   endtask

   task automatic model_reset();
      m_buf = 0; m_val = 0; m_key = '0; m_err = 0; m_vld = 1'b0;
   endtask

   // Sends one frame at edge N and returns #1 after edge N+2 (3-clk spacing).
   task automatic send_frame(input logic [31:0] f);
      @(negedge clk);
      i_frame = f;
      i_frame_vld = 1'b1;
      m_vld = 1'b0;
      if (frame_ok(f)) model_cmd(f[15:8]);
      else model_err();
      @(posedge clk); #1 i_frame_vld = 1'b0;
      @(posedge clk); #1 st_n1 = dut.state_q;
      @(posedge clk); #1 vld_n2 = o_value_vld;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (o_digits !== 24'h0) begin bad++; $display("FAIL reset_digits got=%h exp=000000", o_digits); end
      total++; if (o_dp !== 6'b000001) begin bad++; $display("FAIL reset_dp got=%b exp=000001", o_dp); end
      total++; if (o_value !== 24'h0 || o_value_vld !== 1'b0) begin bad++; $display("FAIL reset_value got=%h/%b exp=000000/0", o_value, o_value_vld); end
      total++; if (o_key !== 8'h0 || o_err_cnt !== 8'h0) begin bad++; $display("FAIL reset_key_err got=%h/%h exp=00/00", o_key, o_err_cnt); end
      total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
      @(negedge clk) rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_digits();
      send_frame(mk(ADDR, 8'h01));
      send_frame(mk(ADDR, 8'h02));
      send_frame(mk(ADDR, 8'h03));
      total++; if (o_digits !== to_bcd(m_buf) || o_digits !== 24'h000123) begin bad++; $display("FAIL digits_123 got=%h exp=%h", o_digits, to_bcd(m_buf)); end
      total++; if (o_dp !== 6'b000001) begin bad++; $display("FAIL digits_dp got=%b exp=000001", o_dp); end
      total++; if (o_key !== m_key) begin bad++; $display("FAIL digits_key got=%h exp=%h", o_key, m_key); end
   endtask

   task automatic test_enter_bs();
      send_frame(mk(ADDR, 8'h0C));
      total++; if (vld_n2 !== 1'b1 || o_value !== to_bcd(m_val)) begin bad++; $display("FAIL enter_commit got=%h/%b exp=%h/1", o_value, vld_n2, to_bcd(m_val)); end
      @(posedge clk); #1;
      total++; if (o_value_vld !== 1'b0) begin bad++; $display("FAIL enter_vld_width got=%b exp=0", o_value_vld); end
      total++; if (o_digits !== to_bcd(m_buf)) begin bad++; $display("FAIL enter_buf_kept got=%h exp=%h", o_digits, to_bcd(m_buf)); end
      send_frame(mk(ADDR, 8'h0B));
      total++; if (o_digits !== to_bcd(m_buf) || o_digits !== 24'h000012) begin bad++; $display("FAIL backspace got=%h exp=%h", o_digits, to_bcd(m_buf)); end
      total++; if (o_dp !== 6'b000001) begin bad++; $display("FAIL backspace_dp got=%b exp=000001", o_dp); end
   endtask

   task automatic test_errors();
      send_frame(32'h00FF0100);
      total++; if (st_n1 !== IDLE) begin bad++; $display("FAIL err_ncmd_state got=%0d exp=%0d", st_n1, IDLE); end
      send_frame(mk(8'h10, 8'h04));
      total++; if (st_n1 !== IDLE) begin bad++; $display("FAIL err_addr_state got=%0d exp=%0d", st_n1, IDLE); end
      total++; if (o_digits !== to_bcd(m_buf)) begin bad++; $display("FAIL err_digits got=%h exp=%h", o_digits, to_bcd(m_buf)); end
      total++; if (o_err_cnt !== 8'(m_err) || o_err_cnt !== 8'd2) begin bad++; $display("FAIL err_cnt got=%0d exp=%0d", o_err_cnt, m_err); end
   endtask

   task automatic test_back_to_back();
      // Frames at edges N, N+1 (CHECK) and N+2 (EXEC): only the first is used.
      @(negedge clk); i_frame = mk(ADDR, 8'h04); i_frame_vld = 1'b1;
      model_cmd(8'h04);
      @(negedge clk); i_frame = mk(ADDR, 8'h06); model_err();
      @(negedge clk); i_frame = mk(ADDR, 8'h07); model_err();
      @(negedge clk); i_frame_vld = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (o_digits !== to_bcd(m_buf)) begin bad++; $display("FAIL b2b_drop_digits got=%h exp=%h", o_digits, to_bcd(m_buf)); end
      total++; if (o_err_cnt !== 8'(m_err)) begin bad++; $display("FAIL b2b_drop_err got=%0d exp=%0d", o_err_cnt, m_err); end
      // Frame and repeat together in HOLD: the frame is processed.
      total++; if (dut.state_q !== HOLD) begin bad++; $display("FAIL b2b_in_hold got=%0d exp=%0d", dut.state_q, HOLD); end
      @(negedge clk); i_frame = mk(ADDR, 8'h08); i_frame_vld = 1'b1; i_rpt_vld = 1'b1;
      model_cmd(8'h08);
      @(negedge clk); i_frame_vld = 1'b0; i_rpt_vld = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (o_digits !== to_bcd(m_buf)) begin bad++; $display("FAIL frame_beats_rpt got=%h exp=%h", o_digits, to_bcd(m_buf)); end
      // Minimum 3-clk spacing: both frames execute.
      send_frame(mk(ADDR, 8'h09));
      send_frame(mk(ADDR, 8'h01));
      total++; if (o_digits !== to_bcd(m_buf) || o_key !== m_key) begin bad++; $display("FAIL spacing3 got=%h/%h exp=%h/%h", o_digits, o_key, to_bcd(m_buf), m_key); end
   endtask

   task automatic test_hold();
      send_frame(mk(ADDR, 8'h0A));
      send_frame(mk(ADDR, 8'h05));
      for (int r = 1; r <= 5; r++) begin
         repeat (RPT_GAP - 4) @(posedge clk);
         #1;
         total++; if (dut.state_q !== HOLD) begin bad++; $display("FAIL hold_before_rpt%0d got=%0d exp=%0d", r, dut.state_q, HOLD); end
         @(negedge clk) i_rpt_vld = 1'b1;
         @(posedge clk); #1 i_rpt_vld = 1'b0;
`ifdef IR_CMD_AUTOREPEAT_EN
         if (r % 4 == 0) model_cmd(8'h05);
`endif
      end
      repeat (HOLD_CYC - 1) @(posedge clk);
      #1;
      total++; if (dut.state_q !== HOLD) begin bad++; $display("FAIL hold_last_cycle got=%0d exp=%0d", dut.state_q, HOLD); end
      @(posedge clk); #1;
      total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL hold_timeout got=%0d exp=%0d", dut.state_q, IDLE); end
      total++; if (o_digits !== to_bcd(m_buf)) begin bad++; $display("FAIL hold_digits got=%h exp=%h", o_digits, to_bcd(m_buf)); end
      total++; if (o_key !== 8'h05) begin bad++; $display("FAIL hold_key got=%h exp=05", o_key); end
   endtask

   task automatic test_overflow_reset();
      send_frame(mk(ADDR, 8'h0A));
      for (int d = 1; d <= 7; d++) send_frame(mk(ADDR, 8'(d)));
      total++; if (o_digits !== to_bcd(m_buf) || o_digits !== 24'h234567) begin bad++; $display("FAIL overflow got=%h exp=%h", o_digits, to_bcd(m_buf)); end
      @(negedge clk); i_frame = mk(ADDR, 8'h08); i_frame_vld = 1'b1;
      @(posedge clk); #1 i_frame_vld = 1'b0;
      @(posedge clk); #1;
      total++; if (dut.state_q !== EXEC) begin bad++; $display("FAIL rst_mid_exec_state got=%0d exp=%0d", dut.state_q, EXEC); end
      rst_n = 1'b0;
      #1;
      total++; if (o_digits !== 24'h0 || o_dp !== 6'b000001 || o_value !== 24'h0) begin bad++; $display("FAIL rst_async_data got=%h/%b/%h exp=000000/000001/000000", o_digits, o_dp, o_value); end
      total++; if (o_key !== 8'h0 || o_err_cnt !== 8'h0 || o_value_vld !== 1'b0 || dut.state_q !== IDLE) begin bad++; $display("FAIL rst_async_ctrl got=%h/%h/%b/%0d exp=00/00/0/0", o_key, o_err_cnt, o_value_vld, dut.state_q); end
      repeat (2) @(posedge clk);
      #1;
      total++; if (o_digits !== 24'h0 || dut.state_q !== IDLE) begin bad++; $display("FAIL rst_no_partial got=%h/%0d exp=000000/0", o_digits, dut.state_q); end
      @(negedge clk) rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_random();
      logic [31:0] f;
      logic [7:0]  c;
      for (int n = 0; n < 60; n++) begin
         c = 8'($urandom_range(0, 12));
         f = mk(ADDR, c);
         if ($urandom_range(0, 9) < 3) f[$urandom_range(0, 31)] ^= 1'b1;
         send_frame(f);
         total++;
         if (o_digits !== to_bcd(m_buf) || o_key !== m_key || o_err_cnt !== 8'(m_err) ||
             o_value !== to_bcd(m_val) || vld_n2 !== m_vld || o_dp !== 6'b000001) begin
            bad++;
            $display("FAIL random_%0d frame=%h got=%h/%h/%0d/%h/%b exp=%h/%h/%0d/%h/%b", n, f,
                     o_digits, o_key, o_err_cnt, o_value, vld_n2,
                     to_bcd(m_buf), m_key, m_err, to_bcd(m_val), m_vld);
         end
      end
   endtask

   task automatic test_saturate();
      for (int n = 0; n < 300; n++) send_frame(32'hFFFF_FFFF);
      total++; if (o_err_cnt !== 8'(m_err) || o_err_cnt !== 8'hFF) begin bad++; $display("FAIL err_saturate got=%0d exp=%0d", o_err_cnt, m_err); end
      total++; if (o_digits !== to_bcd(m_buf)) begin bad++; $display("FAIL saturate_digits got=%h exp=%h", o_digits, to_bcd(m_buf)); end
   endtask

   initial begin
      test_reset();
      test_digits();
      test_enter_bs();
      test_errors();
      test_back_to_back();
      test_hold();
      test_overflow_reset();
      test_random();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
